// File: rtl/i2s_tx_serialiser.sv
// I2S transmit serialiser: 16-bit stereo, 32 BCLK per frame, from a 3.072 MHz clock.
// Sample pairs are buffered in a small FIFO. All framing is derived from a 6-bit
// cycle counter, so BCLK, LRCK and SDATA each come straight from a register bit.
// Handshake: the upstream port transfers a pair on a clk edge where s_valid and
// s_ready are both high. s_ready depends only on registered occupancy, so it never
// combinationally depends on s_valid. A pair held with s_valid=1 must stay stable
// until it is accepted.
module i2s_tx_serialiser #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [15:0]      s_left,
    input  logic [15:0]      s_right,
    output logic [CNT_W-1:0] fill,
    output logic             underrun,
    input  logic             underrun_clr,
    output logic             i2s_bclk,
    output logic             i2s_lrck,
    output logic             i2s_sdata
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic             lk_meta;
    logic             lk;
    logic [5:0]       cnt;
    logic [31:0]      shreg;
    logic [31:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             load_edge;
    logic             shift_edge;

    // Occupancy-based flow control; both sides act on registered state only.
    assign fifo_empty = (fill == '0);
    assign s_ready    = (fill != CNT_W'(FIFO_DEPTH));
    assign push       = s_valid & s_ready;

    // cnt 1 -> 2 loads the next pair; every other odd -> even step shifts.
    assign load_edge  = lk & (cnt == 6'd1);
    assign shift_edge = lk & cnt[0] & (cnt != 6'd1);
    assign pop        = load_edge & ~fifo_empty;

    // Outputs are plain register bits, so they cannot glitch.
    assign i2s_bclk  = cnt[0];
    assign i2s_lrck  = cnt[5];
    assign i2s_sdata = shreg[31];

    // Two-flop synchroniser for the PLL lock indicator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lk_meta <= 1'b0;
            lk      <= 1'b0;
        end else begin
            lk_meta <= pll_locked;
            lk      <= lk_meta;
        end
    end

    // Frame counter and shift register; held silent while the PLL is unlocked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= 6'd0;
            shreg <= 32'd0;
        end else if (!lk) begin
            cnt   <= 6'd0;
            shreg <= 32'd0;
        end else begin
            cnt <= cnt + 6'd1;
            if (load_edge) begin
                shreg <= fifo_empty ? 32'd0 : mem[rd_ptr];
            end else if (shift_edge) begin
                shreg <= {shreg[30:0], 1'b0};
            end
        end
    end

    // Sticky underrun flag; a new underrun takes priority over a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun <= 1'b0;
        end else if (load_edge && fifo_empty) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end

    // FIFO pointers and fill level; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fill <= fill + CNT_W'(1);
            end else if (pop && !push) begin
                fill <= fill - CNT_W'(1);
            end
        end
    end

    // FIFO storage: left sample in the upper half so it is shifted out first.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {s_left, s_right};
        end
    end

endmodule

// File: tb/tb_i2s_tx_serialiser.sv
// Bench for i2s_tx_serialiser. A monitor decodes the I2S pins the way a DAC would
// and compares each complete frame against a queue of accepted sample pairs.
`timescale 1ns/1ps
module tb_i2s_tx_serialiser;

    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             pll_locked;
    logic             s_valid;
    logic             s_ready;
    logic [15:0]      s_left;
    logic [15:0]      s_right;
    logic [CNT_W-1:0] fill;
    logic             underrun;
    logic             underrun_clr;
    logic             i2s_bclk;
    logic             i2s_lrck;
    logic             i2s_sdata;

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    int unsigned lock_base = 0;
    int          silent_frames = 0;
    logic [31:0] exp_q[$];

    i2s_tx_serialiser #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_left      (s_left),
        .s_right     (s_right),
        .fill        (fill),
        .underrun    (underrun),
        .underrun_clr(underrun_clr),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrck    (i2s_lrck),
        .i2s_sdata   (i2s_sdata)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic void check(string name, logic [31:0] got, logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endfunction

    function automatic logic [31:0] rand_pair();
        logic [15:0] l;
        logic [15:0] r;
        l = 16'($urandom_range(1, 65535));
        r = 16'($urandom);
        return {l, r};
    endfunction

    // Edge index after which the frame position equals v, counted from lock.
    function automatic int unsigned next_cnt_edge(int unsigned v);
        int unsigned e;
        e = cyc + 1;
        while (((e - lock_base) % 64) != v) e++;
        return e;
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(int unsigned target);
        while (cyc < target) tick(1);
    endtask

    // After this, frame position p is reached on edge lock_base + p.
    task automatic do_lock();
        pll_locked = 1'b1;
        lock_base  = cyc + 2;
    endtask

    task automatic push_pair(logic [31:0] p);
        int n;
        n = 0;
        s_valid = 1'b1;
        {s_left, s_right} = p;
        while (!s_ready && n < 200) begin
            tick(1);
            n++;
        end
        check("push_ready", 32'(s_ready), 32'd1);
        if (s_ready) exp_q.push_back(p);
        tick(1);
        s_valid = 1'b0;
    endtask

    // Scoreboard: frames of all-zero data are silence and consume nothing.
    function automatic void frame_done(logic [31:0] w);
        if (w == 32'd0) begin
            silent_frames++;
        end else if (exp_q.size() == 0) begin
            check("unexpected_frame", w, 32'd0);
        end else begin
            check("frame_data", w, exp_q.pop_front());
        end
    endfunction

    // Monitor: decode bits on BCLK rising edges; a 3-clk gap in BCLK restarts framing.
    logic        mon_prev = 1'b0;
    logic        mon_run = 1'b0;
    int          mon_since = 0;
    int          mon_slot = 0;
    int          mon_nbits = 0;
    logic [15:0] mon_l = 16'd0;
    logic [15:0] mon_r = 16'd0;

    always @(negedge clk) begin
        if (rst) begin
            mon_prev  = 1'b0;
            mon_run   = 1'b0;
            mon_since = 0;
            mon_nbits = 0;
        end else begin
            mon_since++;
            if (i2s_bclk && !mon_prev) begin
                if (mon_run) begin
                    check("bclk_period", 32'(mon_since), 32'd2);
                    mon_slot = (mon_slot + 1) % 32;
                end else begin
                    mon_slot = 0;
                end
                mon_run   = 1'b1;
                mon_since = 0;
                check("lrck_slot", 32'(i2s_lrck), 32'(mon_slot >= 16));
                if (mon_slot == 0) begin
                    if (mon_nbits == 31) begin
                        mon_r = {mon_r[14:0], i2s_sdata};
                        frame_done({mon_l, mon_r});
                    end
                    mon_nbits = 0;
                end else if (mon_slot <= 16) begin
                    mon_l = {mon_l[14:0], i2s_sdata};
                    mon_nbits++;
                end else begin
                    mon_r = {mon_r[14:0], i2s_sdata};
                    mon_nbits++;
                end
            end else if (mon_since >= 3) begin
                mon_run   = 1'b0;
                mon_nbits = 0;
            end
            mon_prev = i2s_bclk;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        logic [31:0]      cur;
        logic             have;
        logic             acc;
        int               pushes;
        logic [CNT_W-1:0] fmin;
        logic [CNT_W-1:0] fmax;
        logic             ready_ok;
        int unsigned      e;

        rst = 1'b1; pll_locked = 1'b0; s_valid = 1'b0;
        s_left = 16'd0; s_right = 16'd0; underrun_clr = 1'b0;
        tick(3);
        check("rst_fill", 32'(fill), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_bclk", 32'(i2s_bclk), 32'd0);
        check("rst_lrck", 32'(i2s_lrck), 32'd0);
        check("rst_sdata", 32'(i2s_sdata), 32'd0);
        rst = 1'b0;
        tick(2);

        // Lock with an empty FIFO: silence and an underrun on the first load
        do_lock();
        wait_cyc(lock_base);
        check("bclk_still_low", 32'(i2s_bclk), 32'd0);
        wait_cyc(lock_base + 1);
        check("bclk_first_rise", 32'(i2s_bclk), 32'd1);
        check("underrun_before_load", 32'(underrun), 32'd0);
        tick(1);
        check("underrun_first_load", 32'(underrun), 32'd1);
        tick(200);
        check("silence_seen", 32'(silent_frames > 0), 32'd1);
        pll_locked = 1'b0;
        tick(5);
        underrun_clr = 1'b1; tick(1); underrun_clr = 1'b0;
        check("clr_idle", 32'(underrun), 32'd0);

        // Known pair pushed while unlocked, then lock
        push_pair(32'hA5C3_8001);
        check("fill_one", 32'(fill), 32'd1);
        do_lock();
        wait_cyc(lock_base + 2);
        check("fill_after_load", 32'(fill), 32'd0);
        check("no_underrun_on_data", 32'(underrun), 32'd0);
        wait_cyc(lock_base + 66);
        check("underrun_second_frame", 32'(underrun), 32'd1);
        wait_cyc(lock_base + 129);
        underrun_clr = 1'b1; tick(1); underrun_clr = 1'b0;
        check("clr_vs_set", 32'(underrun), 32'd1);
        tick(4);
        underrun_clr = 1'b1; tick(1); underrun_clr = 1'b0;
        check("clr_non_load", 32'(underrun), 32'd0);

        // Continuous s_valid: FIFO saturates, one push per frame
        have = 1'b0; pushes = 0; fmin = '1; fmax = '0; ready_ok = 1'b1; cur = '0;
        for (int i = 0; i < 384; i++) begin
            if (!have) begin
                cur  = rand_pair();
                have = 1'b1;
            end
            s_valid = 1'b1;
            {s_left, s_right} = cur;
            acc = s_ready;
            if (acc) exp_q.push_back(cur);
            if (i >= 256) begin
                if (acc) pushes++;
                if (fill < fmin) fmin = fill;
                if (fill > fmax) fmax = fill;
                if (s_ready != (fill != CNT_W'(FIFO_DEPTH))) ready_ok = 1'b0;
            end
            tick(1);
            if (acc) have = 1'b0;
        end
        s_valid = 1'b0;
        check("stream_pushes_128clk", 32'(pushes), 32'd2);
        check("stream_fill_max", 32'(fmax), 32'd4);
        check("stream_fill_min", 32'(fmin), 32'd3);
        check("stream_ready_rule", 32'(ready_ok), 32'd1);
        check("stream_no_underrun", 32'(underrun), 32'd0);

        // Lock loss at slot 10: silence, interrupted pair dropped, restart on relock
        e = next_cnt_edge(20);
        wait_cyc(e);
        pll_locked = 1'b0;
        tick(3);
        check("unlock_bclk", 32'(i2s_bclk), 32'd0);
        check("unlock_lrck", 32'(i2s_lrck), 32'd0);
        check("unlock_sdata", 32'(i2s_sdata), 32'd0);
        tick(2);
        void'(exp_q.pop_front());
        check("fill_after_unlock", 32'(fill), 32'(exp_q.size()));
        do_lock();
        tick(64 * 6);
        check("drained", 32'(exp_q.size()), 32'd0);
        check("underrun_after_drain", 32'(underrun), 32'd1);

        // Asynchronous reset mid-frame with three pairs queued
        e = next_cnt_edge(2);
        wait_cyc(e);
        for (int i = 0; i < 3; i++) push_pair(rand_pair());
        e = next_cnt_edge(21);
        wait_cyc(e);
        check("fill_three", 32'(fill), 32'd3);
        check("bclk_before_rst", 32'(i2s_bclk), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_bclk", 32'(i2s_bclk), 32'd0);
        check("arst_lrck", 32'(i2s_lrck), 32'd0);
        check("arst_sdata", 32'(i2s_sdata), 32'd0);
        check("arst_fill", 32'(fill), 32'd0);
        check("arst_underrun", 32'(underrun), 32'd0);
        exp_q.delete();
        tick(2);
        rst = 1'b0;
        lock_base = cyc + 2;
        check("post_rst_fill", 32'(fill), 32'd0);
        check("post_rst_s_ready", 32'(s_ready), 32'd1);

        // Random traffic: a busy phase then a sparse phase with underruns
        have = 1'b0;
        for (int i = 0; i < 640; i++) begin
            if (!have && $urandom_range(0, 99) < ((i < 320) ? 4 : 1)) begin
                cur  = rand_pair();
                have = 1'b1;
            end
            s_valid = have;
            if (have) {s_left, s_right} = cur;
            acc = have && s_ready;
            if (acc) exp_q.push_back(cur);
            tick(1);
            if (acc) have = 1'b0;
        end
        s_valid = 1'b0;
        tick(64 * 6);
        check("random_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2s_tx_serialiser.md
Name: i2s_tx_serialiser

Overview:
- Consumes the 3.072 MHz audio PLL output clock and its lock indicator.
- Generates I2S BCLK (1.536 MHz), LRCK (48 kHz) and SDATA for the external audio DAC: 16-bit stereo, 32 BCLK per frame.
- Upstream sound logic supplies stereo samples through a valid/ready port into a small FIFO.
- On FIFO underrun the block plays silence and sets a sticky flag.

Parameters:
- FIFO_DEPTH, 4, sample-pair FIFO entries; power of two, minimum 2.
- CNT_W, 3, width of the fill-level output; must hold FIFO_DEPTH.

Ports:
- clk  in  1  3.072 MHz audio clock from the audio PLL output.
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  1  PLL lock; asynchronous to clk.
- s_valid  in  1  upstream sample pair valid.
- s_ready  out  1  FIFO can accept a pair.
- s_left  in  16  left sample, two's complement.
- s_right  in  16  right sample, two's complement.
- fill  out  CNT_W  current FIFO occupancy.
- underrun  out  1  sticky: a frame was loaded from an empty FIFO.
- underrun_clr  in  1  clears underrun.
- i2s_bclk  out  1  bit clock.
- i2s_lrck  out  1  word select: 0 = left, 1 = right.
- i2s_sdata  out  1  serial data, MSB first.

Behaviour:
- Reset (async, rst=1) clears:
  - FIFO pointers; fill=0.
  - cnt (6-bit) = 0, shreg (32-bit) = 0.
  - underrun = 0 and the lock synchroniser.
  - All outputs = 0, except s_ready = 1 after reset.
- Lock synchroniser: pll_locked passes through a 2-flop synchroniser giving lk.
  - lk=0: cnt held at 0, shreg cleared, bclk/lrck/sdata all 0, no FIFO pops.
  - FIFO pushes are still accepted while lk=0.
- Counter: while lk=1, cnt increments every clk and wraps 63 -> 0; one frame = 64 clk = 48 kHz.
- Output decode (all outputs are direct register bits, so they are glitch-free):
  - i2s_bclk = cnt[0].
  - i2s_lrck = cnt[5].
  - i2s_sdata = shreg[31].
- Slot s = cnt[5:1]. Data changes only on the BCLK falling edge, i.e. on odd -> even cnt transitions.
- Load: on the edge where cnt advances 1 -> 2:
  - FIFO non-empty: pop, and shreg <= {left, right}.
  - FIFO empty: shreg <= 0 and underrun <= 1.
- Shift: on every other odd -> even edge (including 63 -> 0), shreg <= shreg << 1.
- Resulting frame layout (standard I2S one-BCLK delay):
  - Left MSB in slot 1, left LSB in slot 16.
  - Right MSB in slot 17, right LSB in slot 0 of the next frame.
- FIFO:
  - s_ready = (fill != FIFO_DEPTH), computed from registered fill.
  - Push when s_valid & s_ready.
  - Simultaneous push and pop: fill unchanged.
  - Push and pop are evaluated on registered state: an empty FIFO with a same-cycle push still underruns, and the push succeeds. A full FIFO refuses a push even when a pop occurs that cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- underrun_clr: clears underrun next cycle. If clear and a new underrun occur in the same cycle, set wins.
- Latency: a pair pushed at least 1 clk before a load edge is serialised starting that frame; MSB appears at cnt=2.
- pll_locked falling mid-frame:
  - Within 2 clk of synchronisation the output is silent and cnt=0.
  - The partially sent pair is lost and is not re-sent.
  - On relock, framing restarts at cnt=0.

Test Plan:
- Reset then pll_locked=1 with the FIFO empty -> after 2 sync clk, bclk toggles every clk. lrck period is 64 clk with a 32-clk high phase. sdata=0. underrun=1 after the first 1 -> 2 edge.
- Push L=16'hA5C3, R=16'h8001, then lock -> sdata over slots 1..16 = 1010010111000011. Slots 17..31 plus next slot 0 = 1000000000000001. lrck=0 for slots 0..15.
- Hold s_valid=1 continuously with FIFO_DEPTH=4 -> fill reaches 4 and s_ready=0. Thereafter exactly one push per 64 clk and fill oscillates 3/4. No underrun.
- Set underrun, then assert underrun_clr on the same cycle as an underrunning load -> underrun stays 1. Clear on a non-load cycle -> underrun goes to 0.
- Drop pll_locked at slot 10 -> within 3 clk bclk/lrck/sdata=0 and cnt=0. Re-lock -> the next queued pair is sent from slot 1 and the interrupted pair is not repeated.
- Assert rst mid-frame with fill=3 -> all outputs 0 immediately (async); fill=0 and s_ready=1 after release.
